srv_icache_sa: RTL and testbench
================================

Name: srv_icache_sa

Overview:
Parametrised set-associative instruction cache for the schoolRISCV core, sitting between the fetch stage and the external line-fill memory port. Generalises the single-line fully associative cache to NWAYS × NSETS lines of configurable width. Adds tree-PLRU replacement per set, a refill FSM, a cache-disable bypass mode and a single-cycle flush for fence.i.

Parameters:
CACHE_EN, 1, 0 = every request misses and nothing is installed (pure bypass)
NWAYS, 2, ways per set; power of 2, 1..8
NSETS, 4, sets; power of 2, >=1
LINE_W, 128, line width in bits; power of 2, 32..512

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
imem_req_i  in  1  fetch request, accepted only while im_busy_o=0
imAddr  in  32  word address of the instruction
imData  out  32  instruction word; valid when im_drdy=1
im_drdy  out  1  one-cycle response strobe
im_busy_o  out  1  miss in progress; core holds PC and request
flush_i  in  1  invalidate all lines (pulse)
ext_addr_o  out  32  line-aligned word address of the refill
ext_req_o  out  1  refill request, level, held until ext_rsp_i
ext_rsp_i  in  1  refill data valid (one-cycle pulse)
ext_data_i  in  LINE_W  refill line; word k at bits [32k+:32]

Behaviour:
- Derived widths: OFFS_W=log2(LINE_W/32), IDX_W=log2(NSETS) (0 if NSETS=1), TAG_W=32-OFFS_W-IDX_W.
- Address split: offs=imAddr[OFFS_W-1:0], idx=next IDX_W bits, tag=remaining upper bits.
- Storage: per way/set data, tag and valid flops; per set (NWAYS-1) PLRU bits.
- Reset: state=IDLE, all valid=0, all PLRU=0, im_drdy=0, im_busy_o=0, ext_req_o=0, imData=0. Reset mid-miss aborts the refill immediately; no im_drdy follows.
- FSM IDLE:
  - A request is accepted when imem_req_i=1. Address is latched and lookup is combinational on imAddr.
  - Hit: the word is registered into imData, im_drdy=1 the next cycle, PLRU of the set is updated toward the hit way, and the FSM stays in IDLE. Back-to-back hits sustain 1 response/cycle.
  - Miss, or CACHE_EN=0: go to MISS.
- FSM MISS:
  - im_busy_o=1, ext_req_o=1, ext_addr_o={tag,idx,OFFS_W'0} from the latched address.
  - imem_req_i is ignored.
  - On ext_rsp_i: the selected word of ext_data_i is registered into imData, and the line and tag are written into the victim way with valid=1 and PLRU updated (skipped when CACHE_EN=0).
  - Next cycle: im_drdy=1, ext_req_o=0, im_busy_o=0, state=IDLE.
- Victim selection: lowest-index invalid way; if all ways are valid, the tree-PLRU victim. NWAYS=1 always selects way 0.
- PLRU update: tree bits on the path to the accessed way point away from it.
- Flush:
  - In IDLE, flush_i clears all valid and PLRU bits at the next edge. A request in the same cycle is treated as a miss.
  - In MISS, flush is latched as pending. The refill still returns data to the core, but the clear is applied on the ext_rsp_i edge and wins over the install, so the line is not retained.
- ext_rsp_i outside MISS is ignored.

Decomposition:
- Package srv_icache_pkg holds:
  - the state enum (IDLE, MISS);
  - width-derivation functions (offs/idx/tag widths);
  - the word-select helper.
- Sub-module srv_icache_plru, one per set via generate:
  - inputs: valid vector, access way (one-hot), update enable, flush;
  - output: one-hot victim;
  - owns that set's PLRU bits.

Test Plan:
Defaults (2 ways, 4 sets, 128-bit lines), memory latency 3 cycles:
1. Cold miss: req 0x10 -> ext_req_o=1 with ext_addr_o=0x10 until rsp with line {D3,D2,D1,D0}; im_drdy=1 with imData=D0 one cycle after rsp.
2. Hit: req 0x12 after scenario 1 -> im_drdy next cycle with imData=D2, ext_req_o stays 0. Back-to-back 0x11, 0x13 -> D1, D3 on consecutive cycles.
3. Replacement in set 0: fill 0x00 (way0) and 0x10 (way1), hit 0x00, miss 0x20 -> evicts 0x10. Then 0x00 hits, and 0x10 misses with ext_addr_o=0x10.
4. Flush: after scenario 3, flush_i pulse, then req 0x00 -> miss, ext_req_o=1 with ext_addr_o=0x00.
5. Flush during miss: req 0x30 missing, flush_i mid-MISS -> data returned with im_drdy, but a repeated 0x30 misses again.
6. CACHE_EN=0 and reset: repeated req 0x10 -> ext_req_o every time. rst_n low during MISS -> ext_req_o=0 immediately, no im_drdy, and the next req 0x10 misses.

Source files
------------

// File: rtl/srv_icache_pkg.sv
// Shared types and helpers for the set-associative instruction cache.
package srv_icache_pkg;

    typedef enum logic [0:0] {
        IDLE,
        MISS
    } state_e;

    // Widest line the word-select helper accepts.
    localparam int unsigned MAX_LINE_W = 512;

    function automatic int unsigned offs_w(input int unsigned line_w);
        return $clog2(line_w / 32);
    endfunction

    // Yields 0 for a single set.
    function automatic int unsigned idx_w(input int unsigned nsets);
        return $clog2(nsets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned line_w, input int unsigned nsets);
        return 32 - offs_w(line_w) - idx_w(nsets);
    endfunction

    // Pick 32-bit word 'offs' out of a (zero-extended) cache line.
    function automatic logic [31:0] word_sel(input logic [MAX_LINE_W-1:0] line,
                                             input int unsigned offs);
        return 32'(line >> (offs * 32));
    endfunction

endpackage

// File: rtl/srv_icache_plru.sv
// Tree-PLRU replacement state for one cache set.
// Victim is the lowest invalid way, otherwise the way the tree points at.
module srv_icache_plru
    import srv_icache_pkg::*;
#(
    parameter int unsigned NWAYS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NWAYS-1:0] valid,
    input  logic [NWAYS-1:0] access,
    input  logic             upd,
    input  logic             flush,
    output logic [NWAYS-1:0] victim
);

    localparam int unsigned LVLS = $clog2(NWAYS);
    // Keep a dummy bit when there is no tree (single way).
    localparam int unsigned NB   = (NWAYS > 1) ? NWAYS - 1 : 1;

    logic [NB-1:0] bits_q, bits_d;

    // Victim: first invalid way, else walk the tree (bit=0 -> left, 1 -> right).
    always_comb begin
        int unsigned   node;
        logic          found;
        logic [NB-1:0] sh;
        victim = '0;
        found  = 1'b0;
        node   = 0;
        sh     = '0;
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (!found && !valid[w]) begin
                victim[w] = 1'b1;
                found     = 1'b1;
            end
        end
        if (!found) begin
            for (int unsigned l = 0; l < LVLS; l++) begin
                sh   = bits_q >> node;
                node = 2 * node + 1 + 32'(sh[0]);
            end
            victim = NWAYS'(1) << (node - (NWAYS - 1));
        end
    end

    // Update: every node on the path to the accessed way points away from it.
    always_comb begin
        int unsigned n, p, aw;
        bits_d = bits_q;
        n      = 0;
        p      = 0;
        aw     = 0;
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (access[w]) aw = w;
        end
        if (flush) begin
            bits_d = '0;
        end else if (upd) begin
            n = aw + NWAYS - 1;
            for (int unsigned l = 0; l < LVLS; l++) begin
                p      = (n - 1) / 2;
                bits_d = (bits_d & ~(NB'(1) << p)) | (NB'(n == 2 * p + 1) << p);
                n      = p;
            end
        end
    end

    // PLRU bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bits_q <= '0;
        else        bits_q <= bits_d;
    end

endmodule

// File: rtl/srv_icache_sa.sv
// Set-associative instruction cache with tree-PLRU replacement, refill FSM,
// bypass mode (CACHE_EN=0) and single-cycle flush.
module srv_icache_sa
    import srv_icache_pkg::*;
#(
    parameter int unsigned CACHE_EN = 1,
    parameter int unsigned NWAYS    = 2,
    parameter int unsigned NSETS    = 4,
    parameter int unsigned LINE_W   = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_req_i,
    input  logic [31:0]       imAddr,
    output logic [31:0]       imData,
    output logic              im_drdy,
    output logic              im_busy_o,
    input  logic              flush_i,
    output logic [31:0]       ext_addr_o,
    output logic              ext_req_o,
    input  logic              ext_rsp_i,
    input  logic [LINE_W-1:0] ext_data_i
);

    localparam int unsigned OFFS_W  = offs_w(LINE_W);
    localparam int unsigned IDX_W   = idx_w(NSETS);
    localparam int unsigned TAG_W   = tag_w(LINE_W, NSETS);
    localparam int unsigned WORDS   = LINE_W / 32;
    localparam int unsigned IDX_WL  = (IDX_W > 0) ? IDX_W : 1;
    localparam int unsigned OFFS_WL = (OFFS_W > 0) ? OFFS_W : 1;

    state_e              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                drdy_q, drdy_d;
    logic                pend_q, pend_d;

    logic [LINE_W-1:0]   data_q  [NWAYS][NSETS];
    logic [TAG_W-1:0]    tag_q   [NWAYS][NSETS];
    logic [NWAYS-1:0]    valid_q [NSETS];
    logic [NWAYS-1:0]    victim_vec [NSETS];

    logic [OFFS_WL-1:0]  req_offs, lat_offs;
    logic [IDX_WL-1:0]   req_idx, lat_idx, upd_idx;
    logic [TAG_W-1:0]    req_tag, lat_tag;
    logic [NWAYS-1:0]    hit_vec, sel_victim, acc_way;
    logic [31:0]         hit_word;
    logic                clr_all, install, plru_upd;

    // Shifts and masks instead of part-selects so zero-width fields stay legal.
    assign req_offs = OFFS_WL'(imAddr & 32'(WORDS - 1));
    assign req_idx  = IDX_WL'((imAddr >> OFFS_W) & 32'(NSETS - 1));
    assign req_tag  = TAG_W'(imAddr >> (OFFS_W + IDX_W));
    assign lat_offs = OFFS_WL'(addr_q & 32'(WORDS - 1));
    assign lat_idx  = IDX_WL'((addr_q >> OFFS_W) & 32'(NSETS - 1));
    assign lat_tag  = TAG_W'(addr_q >> (OFFS_W + IDX_W));

    assign sel_victim = victim_vec[lat_idx];

    // Combinational lookup on the incoming address.
    always_comb begin
        hit_vec  = '0;
        hit_word = '0;
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (CACHE_EN != 0 && valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
                hit_vec[w] = 1'b1;
                hit_word   = word_sel(MAX_LINE_W'(data_q[w][req_idx]), 32'(req_offs));
            end
        end
    end

    // Next-state, response and storage-control decode.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        drdy_d   = 1'b0;
        pend_d   = pend_q;
        clr_all  = 1'b0;
        install  = 1'b0;
        plru_upd = 1'b0;
        acc_way  = '0;
        upd_idx  = req_idx;
        unique case (state_q)
            IDLE: begin
                if (flush_i) clr_all = 1'b1;
                if (imem_req_i) begin
                    addr_d = imAddr;
                    // A flush in the same cycle turns the lookup into a miss.
                    if (|hit_vec && !flush_i) begin
                        rdata_d  = hit_word;
                        drdy_d   = 1'b1;
                        plru_upd = 1'b1;
                        acc_way  = hit_vec;
                    end else begin
                        state_d = MISS;
                    end
                end
            end
            MISS: begin
                upd_idx = lat_idx;
                if (flush_i) pend_d = 1'b1;
                if (ext_rsp_i) begin
                    rdata_d = word_sel(MAX_LINE_W'(ext_data_i), 32'(lat_offs));
                    drdy_d  = 1'b1;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                    // A pending flush wins over the install.
                    if (pend_q || flush_i) begin
                        clr_all = 1'b1;
                    end else if (CACHE_EN != 0) begin
                        install  = 1'b1;
                        plru_upd = 1'b1;
                        acc_way  = sel_victim;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            drdy_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            drdy_q  <= drdy_d;
            pend_q  <= pend_d;
        end
    end

    // Valid bits: flush clears everything, install sets the victim's bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NSETS; s++) valid_q[s] <= '0;
        end else if (clr_all) begin
            for (int unsigned s = 0; s < NSETS; s++) valid_q[s] <= '0;
        end else if (install) begin
            valid_q[lat_idx] <= valid_q[lat_idx] | sel_victim;
        end
    end

    // Line and tag storage; contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (install) begin
            for (int unsigned w = 0; w < NWAYS; w++) begin
                if (sel_victim[w]) begin
                    data_q[w][lat_idx] <= ext_data_i;
                    tag_q[w][lat_idx]  <= lat_tag;
                end
            end
        end
    end

    for (genvar s = 0; s < NSETS; s++) begin : g_set
        srv_icache_plru #(
            .NWAYS (NWAYS)
        ) u_plru (
            .clk    (clk),
            .rst_n  (rst_n),
            .valid  (valid_q[s]),
            .access (acc_way),
            .upd    (plru_upd && upd_idx == IDX_WL'(s)),
            .flush  (clr_all),
            .victim (victim_vec[s])
        );
    end

    assign imData     = rdata_q;
    assign im_drdy    = drdy_q;
    assign im_busy_o  = (state_q == MISS);
    assign ext_req_o  = (state_q == MISS);
    assign ext_addr_o = (addr_q >> OFFS_W) << OFFS_W;

endmodule

// File: tb/tb_srv_icache_sa.sv
// Directed bench for srv_icache_sa: one cached instance and one bypass instance.
module tb_srv_icache_sa;

    logic         clk;
    logic         rst_n;
    logic         sel;
    logic         req, flush, rsp;
    logic [31:0]  addr;
    logic [127:0] edata;

    int errors = 0;
    int checks = 0;

    logic [31:0] a_data, b_data, a_ext_addr, b_ext_addr;
    logic        a_drdy, b_drdy, a_busy, b_busy, a_ext_req, b_ext_req;

    logic [31:0] o_data, o_ext_addr;
    logic        o_drdy, o_busy, o_ext_req;

    assign o_data     = sel ? b_data : a_data;
    assign o_ext_addr = sel ? b_ext_addr : a_ext_addr;
    assign o_drdy     = sel ? b_drdy : a_drdy;
    assign o_busy     = sel ? b_busy : a_busy;
    assign o_ext_req  = sel ? b_ext_req : a_ext_req;

    srv_icache_sa #(
        .CACHE_EN (1), .NWAYS (2), .NSETS (4), .LINE_W (128)
    ) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req_i (req & ~sel),
        .imAddr     (addr),
        .imData     (a_data),
        .im_drdy    (a_drdy),
        .im_busy_o  (a_busy),
        .flush_i    (flush & ~sel),
        .ext_addr_o (a_ext_addr),
        .ext_req_o  (a_ext_req),
        .ext_rsp_i  (rsp & ~sel),
        .ext_data_i (edata)
    );

    srv_icache_sa #(
        .CACHE_EN (0), .NWAYS (2), .NSETS (4), .LINE_W (128)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req_i (req & sel),
        .imAddr     (addr),
        .imData     (b_data),
        .im_drdy    (b_drdy),
        .im_busy_o  (b_busy),
        .flush_i    (flush & sel),
        .ext_addr_o (b_ext_addr),
        .ext_req_o  (b_ext_req),
        .ext_rsp_i  (rsp & sel),
        .ext_data_i (edata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] a, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0h: observed %h expected %h", tag, a, obs, exp);
        end
    endtask

    // Word k of the line at base b is C0DE0000 + b + k, so any word equals C0DE0000 + addr.
    function automatic logic [127:0] mkline(input logic [31:0] b);
        logic [127:0] l;
        l = '0;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = 32'hC0DE0000 + b + 32'(k);
        return l;
    endfunction

    // fl: 0 none, 1 flush with the request, 2 flush in the middle of the miss.
    task automatic do_miss(input logic [31:0] a, input int fl);
        req   = 1'b1;
        addr  = a;
        flush = (fl == 1);
        tick();
        req   = 1'b0;
        flush = 1'b0;
        chk("miss_ext_req", a, 32'(o_ext_req), 32'd1);
        chk("miss_ext_addr", a, o_ext_addr, a & ~32'h3);
        chk("miss_busy", a, 32'(o_busy), 32'd1);
        chk("miss_no_drdy", a, 32'(o_drdy), 32'd0);
        if (fl == 2) flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("miss_ext_req_held", a, 32'(o_ext_req), 32'd1);
        tick();
        rsp   = 1'b1;
        edata = mkline(a & ~32'h3);
        tick();
        rsp   = 1'b0;
        chk("miss_drdy", a, 32'(o_drdy), 32'd1);
        chk("miss_data", a, o_data, 32'hC0DE0000 + a);
        chk("miss_ext_req_drop", a, 32'(o_ext_req), 32'd0);
        chk("miss_busy_drop", a, 32'(o_busy), 32'd0);
        tick();
        chk("miss_drdy_pulse", a, 32'(o_drdy), 32'd0);
    endtask

    task automatic do_hit(input logic [31:0] a);
        req  = 1'b1;
        addr = a;
        tick();
        req  = 1'b0;
        chk("hit_drdy", a, 32'(o_drdy), 32'd1);
        chk("hit_data", a, o_data, 32'hC0DE0000 + a);
        chk("hit_no_ext_req", a, 32'(o_ext_req), 32'd0);
        chk("hit_busy", a, 32'(o_busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        sel   = 1'b0;
        req   = 1'b0;
        flush = 1'b0;
        rsp   = 1'b0;
        addr  = '0;
        edata = '0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_drdy_a", 0, 32'(a_drdy), 32'd0);
        chk("rst_busy_a", 0, 32'(a_busy), 32'd0);
        chk("rst_ext_req_a", 0, 32'(a_ext_req), 32'd0);
        chk("rst_data_a", 0, a_data, 32'd0);
        chk("rst_ext_req_b", 0, 32'(b_ext_req), 32'd0);
        chk("rst_data_b", 0, b_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // Cold miss then hits, including back-to-back.
        do_miss(32'h10, 0);
        do_hit(32'h12);
        req  = 1'b1;
        addr = 32'h11;
        tick();
        chk("b2b_drdy0", 32'h11, 32'(a_drdy), 32'd1);
        chk("b2b_data0", 32'h11, a_data, 32'hC0DE0011);
        addr = 32'h13;
        tick();
        req  = 1'b0;
        chk("b2b_drdy1", 32'h13, 32'(a_drdy), 32'd1);
        chk("b2b_data1", 32'h13, a_data, 32'hC0DE0013);

        // Replacement in set 0 from a clean cache.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_miss(32'h00, 0);
        do_miss(32'h10, 0);
        do_hit(32'h00);
        do_miss(32'h20, 0);
        do_hit(32'h01);
        do_miss(32'h10, 0);

        // Flush in IDLE.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        do_miss(32'h00, 0);

        // Flush during a miss: data still delivered, line not kept.
        do_miss(32'h30, 2);
        do_miss(32'h30, 0);
        do_hit(32'h31);
        // Flush together with a request that would otherwise hit.
        do_miss(32'h31, 1);
        do_hit(32'h32);

        // Bypass instance always misses.
        sel = 1'b1;
        tick();
        do_miss(32'h10, 0);
        do_miss(32'h10, 0);

        // Reset in the middle of a miss.
        req  = 1'b1;
        addr = 32'h10;
        tick();
        req  = 1'b0;
        chk("rstmiss_ext_req", 32'h10, 32'(b_ext_req), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstmiss_ext_req_drop", 32'h10, 32'(b_ext_req), 32'd0);
        chk("rstmiss_busy_drop", 32'h10, 32'(b_busy), 32'd0);
        rsp   = 1'b1;
        edata = mkline(32'h10);
        tick();
        rsp   = 1'b0;
        rst_n = 1'b1;
        chk("rstmiss_no_drdy0", 32'h10, 32'(b_drdy), 32'd0);
        tick();
        chk("rstmiss_no_drdy1", 32'h10, 32'(b_drdy), 32'd0);
        do_miss(32'h10, 0);

        // Reset also invalidated the cached instance.
        sel = 1'b0;
        tick();
        do_miss(32'h32, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
